// File: rtl/iss_dispatch_pkg.sv
// Shared constants and types for the REN->ISS dispatch path.
// Contents:
//   RENISS_WIDTH      default width of a renamed instruction word
//   BUF_DEPTH_LG      default log2 depth of the in-order dispatch buffer
//   CNT_WIDTH         default width of performance counters
//   REN_MEMWRITE_BIT  MemWrite flag position in the renamed word (ISS uses the same)
//   REN_MEMREAD_BIT   MemRead flag position in the renamed word (ISS uses the same)
//   tgt_e             issue-queue target of an instruction
//   steer()           maps the memory flags to a target queue
package iss_dispatch_pkg;

  localparam int unsigned RENISS_WIDTH     = 151;
  localparam int unsigned BUF_DEPTH_LG     = 2;
  localparam int unsigned CNT_WIDTH        = 32;
  localparam int unsigned REN_MEMWRITE_BIT = 40;
  localparam int unsigned REN_MEMREAD_BIT  = 39;

  typedef enum logic {
    TGT_IQ  = 1'b0,
    TGT_LSQ = 1'b1
  } tgt_e;

  function automatic tgt_e steer(input logic mem_write, input logic mem_read);
    return (mem_write | mem_read) ? TGT_LSQ : TGT_IQ;
  endfunction

endpackage

// File: rtl/iss_dispatch_if.sv
// REN->dispatch->ISS handshake bundle.
// Signals:
//   REN_valid_IN / REN_data_IN   renamed instruction offered by REN
//   REN_stall_OUT                dispatch buffer full, REN must hold
//   IQ_full_IN / LSQ_full_IN     ISS queue full flags
//   IQ_pushReq_OUT / IQ_pushData_OUT    push of head entry into IQ
//   LSQ_pushReq_OUT / LSQ_pushData_OUT  push of head entry into LSQ
// Modports:
//   master  the dispatch block (drives stall and push requests)
//   slave   the surrounding REN/ISS side
interface iss_dispatch_if
  import iss_dispatch_pkg::*;
#(
  parameter int unsigned W = RENISS_WIDTH
);

  logic         REN_valid_IN;
  logic [W-1:0] REN_data_IN;
  logic         REN_stall_OUT;
  logic         IQ_full_IN;
  logic         LSQ_full_IN;
  logic         IQ_pushReq_OUT;
  logic [W-1:0] IQ_pushData_OUT;
  logic         LSQ_pushReq_OUT;
  logic [W-1:0] LSQ_pushData_OUT;

  modport master (
    input  REN_valid_IN, REN_data_IN, IQ_full_IN, LSQ_full_IN,
    output REN_stall_OUT, IQ_pushReq_OUT, IQ_pushData_OUT,
           LSQ_pushReq_OUT, LSQ_pushData_OUT
  );

  modport slave (
    output REN_valid_IN, REN_data_IN, IQ_full_IN, LSQ_full_IN,
    input  REN_stall_OUT, IQ_pushReq_OUT, IQ_pushData_OUT,
           LSQ_pushReq_OUT, LSQ_pushData_OUT
  );

endinterface

// File: rtl/iss_dispatch_buf.sv
// dispatch_buf: in-order circular buffer of 2**DEPTH_LG entries, W bits each.
// Ports:
//   CLK, RESET   clock, asynchronous active-low reset
//   push_i       write wdata_i at tail (caller guarantees not full)
//   pop_i        retire head entry (caller guarantees not empty)
//   flush_i      drop all entries; overrides push/pop
//   wdata_i      entry to write
//   head_o       current head entry (undefined content when empty)
//   count_o      number of valid entries, 0..2**DEPTH_LG
module dispatch_buf #(
  parameter int unsigned W        = 152,
  parameter int unsigned DEPTH_LG = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [W-1:0]      wdata_i,
  output logic [W-1:0]      head_o,
  output logic [DEPTH_LG:0] count_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LG;

  logic [W-1:0]        mem_q [DEPTH];
  logic [DEPTH_LG-1:0] head_q, head_d;
  logic [DEPTH_LG-1:0] tail_q, tail_d;
  logic [DEPTH_LG:0]   count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointers are exactly DEPTH_LG bits wide, so they wrap mod depth.
      if (push_i) tail_d = tail_q + (DEPTH_LG)'(1);
      if (pop_i)  head_d = head_q + (DEPTH_LG)'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + (DEPTH_LG + 1)'(1);
        2'b01:   count_d = count_q - (DEPTH_LG + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only slots below count are ever observed.
  always_ff @(posedge CLK) begin
    if (push_i && !flush_i) mem_q[tail_q] <= wdata_i;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/iss_dispatch.sv
// iss_dispatch: buffers renamed instructions in order and pushes the head
// entry into either the IQ or the LSQ, at most one push per cycle.
// Ports:
//   CLK, RESET         clock, asynchronous active-low reset
//   FREEZE             global hold: no accept, no push, counters hold
//   FLUSH_IN           synchronous discard of all buffered entries (beats FREEZE)
//   ren_iss            REN/IQ/LSQ handshake bundle (master side)
//   IQ_dispCount_OUT   instructions pushed to IQ
//   LSQ_dispCount_OUT  instructions pushed to LSQ
//   stallCycles_OUT    cycles with head valid but its target queue full
module iss_dispatch
  import iss_dispatch_pkg::*;
#(
  parameter int unsigned RENISS_WIDTH = iss_dispatch_pkg::RENISS_WIDTH,
  parameter int unsigned BUF_DEPTH_LG = iss_dispatch_pkg::BUF_DEPTH_LG,
  parameter int unsigned CNT_WIDTH    = iss_dispatch_pkg::CNT_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 FREEZE,
  input  logic                 FLUSH_IN,
  iss_dispatch_if.master       ren_iss,
  output logic [CNT_WIDTH-1:0] IQ_dispCount_OUT,
  output logic [CNT_WIDTH-1:0] LSQ_dispCount_OUT,
  output logic [CNT_WIDTH-1:0] stallCycles_OUT
);

  localparam logic [BUF_DEPTH_LG:0] DEPTH_C = (BUF_DEPTH_LG + 1)'(1 << BUF_DEPTH_LG);

  logic [RENISS_WIDTH:0]   wr_entry;
  logic [RENISS_WIDTH:0]   head_entry;
  logic [BUF_DEPTH_LG:0]   count;
  logic                    empty, full, hold, accept;
  logic                    iq_req, lsq_req, pop, head_blocked;
  tgt_e                    head_tgt;
  logic [CNT_WIDTH-1:0]    iq_cnt_q, lsq_cnt_q, stall_cnt_q;

  // Target is resolved once at accept and carried as the entry's top bit.
  assign wr_entry = {steer(ren_iss.REN_data_IN[REN_MEMWRITE_BIT],
                           ren_iss.REN_data_IN[REN_MEMREAD_BIT]),
                     ren_iss.REN_data_IN};

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign hold     = FREEZE | FLUSH_IN;
  assign accept   = ren_iss.REN_valid_IN & ~full & ~hold;
  assign head_tgt = tgt_e'(head_entry[RENISS_WIDTH]);

  assign iq_req  = ~empty & (head_tgt == TGT_IQ)  & ~ren_iss.IQ_full_IN  & ~hold;
  assign lsq_req = ~empty & (head_tgt == TGT_LSQ) & ~ren_iss.LSQ_full_IN & ~hold;
  assign pop     = iq_req | lsq_req;

  // Strict in-order: a full target blocks the head even if the other queue has room.
  assign head_blocked = ~empty & ~hold &
                        ((head_tgt == TGT_IQ) ? ren_iss.IQ_full_IN : ren_iss.LSQ_full_IN);

  dispatch_buf #(
    .W        (RENISS_WIDTH + 1),
    .DEPTH_LG (BUF_DEPTH_LG)
  ) u_buf (
    .CLK     (CLK),
    .RESET   (RESET),
    .push_i  (accept),
    .pop_i   (pop),
    .flush_i (FLUSH_IN),
    .wdata_i (wr_entry),
    .head_o  (head_entry),
    .count_o (count)
  );

  assign ren_iss.REN_stall_OUT    = full;
  assign ren_iss.IQ_pushReq_OUT   = iq_req;
  assign ren_iss.LSQ_pushReq_OUT  = lsq_req;
  assign ren_iss.IQ_pushData_OUT  = iq_req  ? head_entry[RENISS_WIDTH-1:0] : '0;
  assign ren_iss.LSQ_pushData_OUT = lsq_req ? head_entry[RENISS_WIDTH-1:0] : '0;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      iq_cnt_q    <= '0;
      lsq_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (iq_req)       iq_cnt_q    <= iq_cnt_q    + CNT_WIDTH'(1);
      if (lsq_req)      lsq_cnt_q   <= lsq_cnt_q   + CNT_WIDTH'(1);
      if (head_blocked) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign IQ_dispCount_OUT  = iq_cnt_q;
  assign LSQ_dispCount_OUT = lsq_cnt_q;
  assign stallCycles_OUT   = stall_cnt_q;

endmodule

// File: tb/tb_iss_dispatch.sv
module tb_iss_dispatch;

  localparam int unsigned W = 151;

  logic CLK = 1'b0;
  logic RESET;
  logic FREEZE;
  logic FLUSH_IN;
  logic [31:0] IQ_dispCount_OUT, LSQ_dispCount_OUT, stallCycles_OUT;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb_q [$];
  logic [31:0]  exp_iq_cnt, exp_lsq_cnt, exp_stall_cnt;

  iss_dispatch_if #(.W(W)) bus ();

  iss_dispatch #(
    .RENISS_WIDTH (W),
    .BUF_DEPTH_LG (2),
    .CNT_WIDTH    (32)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .FREEZE            (FREEZE),
    .FLUSH_IN          (FLUSH_IN),
    .ren_iss           (bus),
    .IQ_dispCount_OUT  (IQ_dispCount_OUT),
    .LSQ_dispCount_OUT (LSQ_dispCount_OUT),
    .stallCycles_OUT   (stallCycles_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] memflags);
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    r[40:39] = memflags;
    return r[W-1:0];
  endfunction

  // Reference model: scoreboard of buffered words, compared at every negedge.
  always @(negedge CLK) begin : model
    logic         nonempty, hmem, hold, ei, el, blk, acc;
    logic [W-1:0] hd;
    if (!RESET) begin
      sb_q.delete();
      exp_iq_cnt    = '0;
      exp_lsq_cnt   = '0;
      exp_stall_cnt = '0;
      chk("rst_iq_req",  bus.IQ_pushReq_OUT,  '0);
      chk("rst_lsq_req", bus.LSQ_pushReq_OUT, '0);
      chk("rst_stall",   bus.REN_stall_OUT,   '0);
      chk("rst_iq_cnt",  IQ_dispCount_OUT,    '0);
    end else begin
      nonempty = (sb_q.size() != 0);
      hd       = nonempty ? sb_q[0] : '0;
      hmem     = hd[40] | hd[39];
      hold     = FREEZE | FLUSH_IN;
      ei  = nonempty & ~hmem & ~bus.IQ_full_IN  & ~hold;
      el  = nonempty &  hmem & ~bus.LSQ_full_IN & ~hold;
      blk = nonempty & ~hold & (hmem ? bus.LSQ_full_IN : bus.IQ_full_IN);
      acc = bus.REN_valid_IN & (sb_q.size() < 4) & ~hold;
      chk("iq_req",    bus.IQ_pushReq_OUT,   ei);
      chk("lsq_req",   bus.LSQ_pushReq_OUT,  el);
      chk("iq_data",   bus.IQ_pushData_OUT,  ei ? hd : '0);
      chk("lsq_data",  bus.LSQ_pushData_OUT, el ? hd : '0);
      chk("ren_stall", bus.REN_stall_OUT,    sb_q.size() == 4);
      chk("iq_cnt",    IQ_dispCount_OUT,     exp_iq_cnt);
      chk("lsq_cnt",   LSQ_dispCount_OUT,    exp_lsq_cnt);
      chk("stall_cnt", stallCycles_OUT,      exp_stall_cnt);
      if (FLUSH_IN) begin
        sb_q.delete();
      end else if (!FREEZE) begin
        if (ei | el) void'(sb_q.pop_front());
        if (acc) sb_q.push_back(bus.REN_data_IN);
        if (ei)  exp_iq_cnt++;
        if (el)  exp_lsq_cnt++;
        if (blk) exp_stall_cnt++;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] w_alu, w_ld, w_add;
    logic [W-1:0] w_fill [5];
    logic [31:0]  snap_iq, snap_lsq, snap_stall;

    RESET    = 1'b0;
    FREEZE   = 1'b0;
    FLUSH_IN = 1'b0;
    bus.REN_valid_IN = 1'b0;
    bus.REN_data_IN  = '0;
    bus.IQ_full_IN   = 1'b0;
    bus.LSQ_full_IN  = 1'b0;
    #1;
    chk("init_stall",   bus.REN_stall_OUT,  '0);
    chk("init_iq_req",  bus.IQ_pushReq_OUT, '0);
    chk("init_iq_data", bus.IQ_pushData_OUT, '0);
    tick();
    tick();
    RESET = 1'b1;

    // ALU op into empty buffer: push one cycle after accept.
    w_alu = mk(2'b00);
    bus.REN_valid_IN = 1'b1;
    bus.REN_data_IN  = w_alu;
    tick();
    bus.REN_valid_IN = 1'b0;
    settle();
    chk("alu_iq_req",   bus.IQ_pushReq_OUT,  1'b1);
    chk("alu_iq_data",  bus.IQ_pushData_OUT, w_alu);
    chk("alu_lsq_req",  bus.LSQ_pushReq_OUT, 1'b0);
    tick();
    settle();
    chk("alu_iq_cnt",   IQ_dispCount_OUT,    32'd1);
    chk("alu_iq_idle",  bus.IQ_pushReq_OUT,  1'b0);

    // Load then add with LSQ full for 5 cycles: head-of-line block.
    w_ld  = mk(2'b01);
    w_add = mk(2'b00);
    bus.LSQ_full_IN  = 1'b1;
    bus.REN_valid_IN = 1'b1;
    bus.REN_data_IN  = w_ld;
    tick();
    bus.REN_data_IN = w_add;
    settle();
    chk("hol_iq_req0", bus.IQ_pushReq_OUT, 1'b0);
    tick();
    bus.REN_valid_IN = 1'b0;
    for (int i = 1; i < 5; i++) begin
      settle();
      chk("hol_iq_req", bus.IQ_pushReq_OUT, 1'b0);
      tick();
    end
    bus.LSQ_full_IN = 1'b0;
    settle();
    chk("hol_stall_cnt", stallCycles_OUT,      32'd5);
    chk("hol_lsq_req",   bus.LSQ_pushReq_OUT,  1'b1);
    chk("hol_lsq_data",  bus.LSQ_pushData_OUT, w_ld);
    chk("hol_iq_wait",   bus.IQ_pushReq_OUT,   1'b0);
    tick();
    settle();
    chk("hol_iq_req_go", bus.IQ_pushReq_OUT,   1'b1);
    chk("hol_iq_data",   bus.IQ_pushData_OUT,  w_add);
    tick();
    settle();
    chk("hol_lsq_cnt",   LSQ_dispCount_OUT,    32'd1);
    chk("hol_iq_cnt",    IQ_dispCount_OUT,     32'd2);

    // Fill 4 entries with both queues full; 5th offer is held off.
    bus.IQ_full_IN  = 1'b1;
    bus.LSQ_full_IN = 1'b1;
    for (int i = 0; i < 5; i++) w_fill[i] = mk(2'b00);
    bus.REN_valid_IN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.REN_data_IN = w_fill[i];
      tick();
    end
    bus.REN_data_IN = w_fill[4];
    settle();
    chk("full_stall", bus.REN_stall_OUT, 1'b1);
    tick();
    bus.REN_valid_IN = 1'b0;
    settle();
    chk("full_stall_held", bus.REN_stall_OUT, 1'b1);
    bus.IQ_full_IN = 1'b0;
    #1;
    chk("full_pop_req",   bus.IQ_pushReq_OUT,  1'b1);
    chk("full_pop_data",  bus.IQ_pushData_OUT, w_fill[0]);
    chk("full_no_bypass", bus.REN_stall_OUT,   1'b1);
    tick();
    settle();
    chk("full_stall_clr", bus.REN_stall_OUT,   1'b0);
    chk("full_pop2_data", bus.IQ_pushData_OUT, w_fill[1]);
    repeat (4) tick();
    bus.LSQ_full_IN = 1'b0;

    // Continuous stream for 20 cycles: count stays at 1, pointers wrap.
    bus.REN_valid_IN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.REN_data_IN = mk(2'($urandom_range(0, 3)));
      settle();
      chk("stream_stall", bus.REN_stall_OUT, 1'b0);
      tick();
    end
    bus.REN_valid_IN = 1'b0;
    tick();
    tick();

    // FREEZE alone: no push, resumes after release.
    bus.REN_valid_IN = 1'b1;
    bus.REN_data_IN  = mk(2'b00);
    tick();
    bus.REN_valid_IN = 1'b0;
    FREEZE = 1'b1;
    settle();
    chk("frz_iq_req", bus.IQ_pushReq_OUT, 1'b0);
    tick();
    FREEZE = 1'b0;
    settle();
    chk("frz_resume", bus.IQ_pushReq_OUT, 1'b1);
    tick();

    // FLUSH with FREEZE at the same edge: buffer empties, counters hold.
    bus.IQ_full_IN   = 1'b1;
    bus.REN_valid_IN = 1'b1;
    bus.REN_data_IN  = mk(2'b00);
    tick();
    bus.REN_data_IN  = mk(2'b10);
    tick();
    bus.REN_valid_IN = 1'b0;
    bus.IQ_full_IN   = 1'b0;
    FLUSH_IN = 1'b1;
    FREEZE   = 1'b1;
    settle();
    chk("flush_iq_req",  bus.IQ_pushReq_OUT,  1'b0);
    chk("flush_lsq_req", bus.LSQ_pushReq_OUT, 1'b0);
    snap_iq    = exp_iq_cnt;
    snap_lsq   = exp_lsq_cnt;
    snap_stall = exp_stall_cnt;
    tick();
    FLUSH_IN = 1'b0;
    FREEZE   = 1'b0;
    settle();
    chk("flush_empty",     bus.IQ_pushReq_OUT,  1'b0);
    chk("flush_iq_cnt",    IQ_dispCount_OUT,    snap_iq);
    chk("flush_lsq_cnt",   LSQ_dispCount_OUT,   snap_lsq);
    chk("flush_stall_cnt", stallCycles_OUT,     snap_stall);
    tick();

    // Asynchronous reset with 3 entries buffered.
    bus.IQ_full_IN   = 1'b1;
    bus.REN_valid_IN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.REN_data_IN = mk(2'b00);
      tick();
    end
    bus.REN_valid_IN = 1'b0;
    bus.IQ_full_IN   = 1'b0;
    #1;
    chk("rst_pre_req", bus.IQ_pushReq_OUT, 1'b1);
    RESET = 1'b0;
    #1;
    chk("rst_async_iq_req",   bus.IQ_pushReq_OUT,   1'b0);
    chk("rst_async_iq_data",  bus.IQ_pushData_OUT,  '0);
    chk("rst_async_lsq_req",  bus.LSQ_pushReq_OUT,  1'b0);
    chk("rst_async_stall",    bus.REN_stall_OUT,    1'b0);
    chk("rst_async_iq_cnt",   IQ_dispCount_OUT,     '0);
    chk("rst_async_lsq_cnt",  LSQ_dispCount_OUT,    '0);
    chk("rst_async_stall_cnt", stallCycles_OUT,     '0);
    tick();
    RESET = 1'b1;
    settle();
    chk("rst_post_stall", bus.REN_stall_OUT,   1'b0);
    chk("rst_post_empty", bus.IQ_pushReq_OUT,  1'b0);
    w_alu = mk(2'b00);
    tick();
    bus.REN_valid_IN = 1'b1;
    bus.REN_data_IN  = w_alu;
    tick();
    bus.REN_valid_IN = 1'b0;
    settle();
    chk("rst_post_push", bus.IQ_pushData_OUT, w_alu);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
